// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_e : fetch FSM states
//   PC_INC        : sequential PC step (one 32-bit instruction)
package if_fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // ready to issue a request
    S_WAIT = 2'd1,  // request outstanding
    S_HOLD = 2'd2,  // word captured, waiting for IF/ID
    S_KILL = 2'd3   // drain outstanding request, drop its data
  } fetch_state_e;

  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, handshakes with the instruction
// memory and holds each fetched word until the IF/ID register takes it.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   stall[5:0]        : bit0 stalls the PC stage, bit1 stalls IF/ID
//   ex_b_flag/target  : EX redirect (higher priority)
//   id_b_flag/target  : ID redirect
//   mem_req/addr      : instruction memory request
//   mem_ready/rdata   : memory response, completes current request
//   if_pc/if_inst     : presented instruction (zero when no word held)
//   if_stall_req      : 1 when no valid instruction is presented
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        stall,
  input  logic              ex_b_flag,
  input  logic [ADDR_W-1:0] ex_b_target,
  input  logic              id_b_flag,
  input  logic [ADDR_W-1:0] id_b_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [INST_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              if_stall_req
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] kill_addr_q, kill_addr_d;
  logic [INST_W-1:0] inst_q, inst_d;

  logic              redir;
  logic [ADDR_W-1:0] redir_tgt;
  logic              req_issue;
  logic              hold;
  logic              unused_stall;

  assign unused_stall = ^stall[5:2];

  assign redir     = ex_b_flag | id_b_flag;
  assign req_issue = (state_q == S_REQ) && !stall[0];
  assign hold      = (state_q == S_HOLD);

  always_comb begin
    redir_tgt      = ex_b_flag ? ex_b_target : id_b_target;
    redir_tgt[1:0] = 2'b00;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_addr_d = kill_addr_q;
    inst_d      = inst_q;
    case (state_q)
      S_REQ: begin
        if (req_issue) begin
          // A request issued this cycle is already on the bus, so a redirect
          // must still let it complete (drained in S_KILL if not ready yet).
          if (redir) begin
            pc_d = redir_tgt;
            if (!mem_ready) begin
              state_d     = S_KILL;
              kill_addr_d = pc_q;
            end
          end else if (mem_ready) begin
            inst_d  = mem_rdata;
            state_d = S_HOLD;
          end else begin
            state_d = S_WAIT;
          end
        end else if (redir) begin
          pc_d = redir_tgt;
        end
      end
      S_WAIT: begin
        if (redir) begin
          pc_d = redir_tgt;
          if (mem_ready) begin
            state_d = S_REQ;
          end else begin
            state_d     = S_KILL;
            kill_addr_d = pc_q;
          end
        end else if (mem_ready) begin
          inst_d  = mem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redir) begin
          pc_d    = redir_tgt;
          inst_d  = '0;
          state_d = S_REQ;
        end else if (!stall[1]) begin
          pc_d    = pc_q + ADDR_W'(PC_INC);
          state_d = S_REQ;
        end
      end
      S_KILL: begin
        if (redir) pc_d = redir_tgt;
        if (mem_ready) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      kill_addr_q <= RESET_PC;
      inst_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_addr_q <= kill_addr_d;
      inst_q      <= inst_d;
    end
  end

  // Gated by rst so the request drops the instant reset is asserted.
  assign mem_req      = rst && ((state_q == S_WAIT) || (state_q == S_KILL) || req_issue);
  assign mem_addr     = (state_q == S_KILL) ? kill_addr_q : pc_q;
  assign if_pc        = hold ? pc_q : '0;
  assign if_inst      = hold ? inst_q : '0;
  assign if_stall_req = !hold;

endmodule

// File: tb/tb_if_fetch.sv
module tb_if_fetch;

  localparam logic [31:0] K        = 32'hA5A5_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  stall = '0;
  logic        ex_b_flag = 1'b0;
  logic [31:0] ex_b_target = '0;
  logic        id_b_flag = 1'b0;
  logic [31:0] id_b_target = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_stall_req;

  if_fetch #(.ADDR_W(32), .INST_W(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_b_flag(ex_b_flag), .ex_b_target(ex_b_target),
    .id_b_flag(id_b_flag), .id_b_target(id_b_target),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .if_pc(if_pc), .if_inst(if_inst), .if_stall_req(if_stall_req)
  );

  always #5 clk = ~clk;

  // Memory responder: a request is answered after lat extra cycles.
  int   lat = 0;
  int   cnt = 0;
  logic force_rdy = 1'b0;
  always @(posedge clk) begin
    if (mem_req && !mem_ready) cnt <= cnt + 1;
    else cnt <= 0;
  end
  assign mem_ready = force_rdy | (mem_req && (cnt >= lat));
  assign mem_rdata = mem_addr ^ K;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: the PC the next presented instruction must carry,
  // plus last-cycle observations for handshake and hold rules.
  logic [31:0] exp_pc = RESET_PC;
  bit          pv = 0, p_req = 0, p_rdy = 0, p_pres = 0, p_st1 = 0, p_redir = 0;
  logic [31:0] p_addr = '0, p_pc = '0, p_inst = '0;
  logic [31:0] acc_pc[$];
  logic [31:0] acc_inst[$];
  logic        s_req, s_sr;
  logic [31:0] s_addr, s_pc, s_inst;

  task automatic tick();
    bit redir, pres;
    @(negedge clk);
    s_req = mem_req; s_addr = mem_addr; s_sr = if_stall_req;
    s_pc = if_pc; s_inst = if_inst;
    if (!rst) begin
      chk("rst_req", 32'(mem_req), 32'd0);
      chk("rst_stallreq", 32'(if_stall_req), 32'd1);
      chk("rst_pc", if_pc, 32'd0);
      chk("rst_addr", mem_addr, RESET_PC);
      exp_pc = RESET_PC;
      pv = 0;
    end else begin
      pres = !if_stall_req;
      if (!pres) begin
        chk("bubble_pc", if_pc, 32'd0);
        chk("bubble_inst", if_inst, 32'd0);
      end else begin
        chk("pres_pc", if_pc, exp_pc);
        chk("pres_inst", if_inst, if_pc ^ K);
        if (stall[1]) chk("hold_noreq", 32'(mem_req), 32'd0);
      end
      if (pv && p_req && !p_rdy) begin
        chk("hs_req", 32'(mem_req), 32'd1);
        chk("hs_addr", mem_addr, p_addr);
      end else if (mem_req) begin
        chk("req_addr", mem_addr, exp_pc);
      end
      if (pv && p_pres && p_st1 && !p_redir) begin
        chk("hold_valid", 32'(if_stall_req), 32'd0);
        chk("hold_pc", if_pc, p_pc);
        chk("hold_inst", if_inst, p_inst);
      end
      redir = ex_b_flag || id_b_flag;
      if (pres && !stall[1] && !redir) begin
        acc_pc.push_back(if_pc);
        acc_inst.push_back(if_inst);
      end
      if (redir) exp_pc = (ex_b_flag ? ex_b_target : id_b_target) & ~32'd3;
      else if (pres && !stall[1]) exp_pc = exp_pc + 32'd4;
      pv = 1; p_req = mem_req; p_rdy = mem_ready; p_addr = mem_addr;
      p_pres = pres; p_st1 = stall[1]; p_redir = redir;
      p_pc = if_pc; p_inst = if_inst;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; stall = '0; ex_b_flag = 1'b0; id_b_flag = 1'b0;
    ex_b_target = '0; id_b_target = '0; force_rdy = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    acc_pc.delete();
    acc_inst.delete();
  endtask

  task automatic wait_pres(input string name, input int max, output int n);
    n = 0;
    for (int i = 0; i < max; i++) begin
      tick();
      n++;
      if (!s_sr) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no instruction presented within %0d cycles", name, max);
  endtask

  initial begin
    logic [5:0] seq;
    int n;

    // Zero-wait memory, free-running
    lat = 0;
    do_reset();
    seq = '0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seq = {seq[4:0], s_sr};
    end
    chk("t1_stallreq_seq", 32'(seq), 32'b101010);
    chk("t1_count", 32'(acc_pc.size()), 32'd3);
    if (acc_pc.size() == 3) begin
      chk("t1_pc0", acc_pc[0], 32'h0000_0000);
      chk("t1_inst0", acc_inst[0], 32'hA5A5_0000);
      chk("t1_pc1", acc_pc[1], 32'h0000_0004);
      chk("t1_inst1", acc_inst[1], 32'hA5A5_0004);
      chk("t1_pc2", acc_pc[2], 32'h0000_0008);
      chk("t1_inst2", acc_inst[2], 32'hA5A5_0008);
    end

    // 3-cycle memory
    lat = 2;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_req", 32'(s_req), 32'd1);
      chk("t2_addr", s_addr, 32'h0);
      chk("t2_stallreq", 32'(s_sr), 32'd1);
    end
    tick();
    chk("t2_valid", 32'(s_sr), 32'd0);
    chk("t2_inst", s_inst, 32'hA5A5_0000);

    // IF/ID stalled while holding
    lat = 0;
    do_reset();
    stall = 6'b000010;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_pc", s_pc, 32'h0);
      chk("t3_inst", s_inst, 32'hA5A5_0000);
      chk("t3_req", 32'(s_req), 32'd0);
    end
    stall = '0;
    tick();
    tick();
    chk("t3_next_req", 32'(s_req), 32'd1);
    chk("t3_next_addr", s_addr, 32'h4);

    // EX redirect while waiting: killed word never shown
    lat = 2;
    do_reset();
    tick();
    ex_b_flag = 1'b1; ex_b_target = 32'h0000_0103;
    tick();
    ex_b_flag = 1'b0;
    tick();
    chk("t4_kill_req", 32'(s_req), 32'd1);
    chk("t4_kill_addr", s_addr, 32'h0);
    tick();
    chk("t4_new_addr", s_addr, 32'h100);
    wait_pres("t4_pres", 8, n);
    chk("t4_latency", 32'(n), 32'd3);
    chk("t4_pc", s_pc, 32'h100);
    chk("t4_inst", s_inst, 32'hA5A5_0100);
    chk("t4_count", 32'(acc_pc.size()), 32'd1);

    // EX and ID redirect together: EX wins
    lat = 0;
    do_reset();
    stall = 6'b000010;
    tick();
    ex_b_flag = 1'b1; ex_b_target = 32'h200;
    id_b_flag = 1'b1; id_b_target = 32'h300;
    tick();
    ex_b_flag = 1'b0; id_b_flag = 1'b0; stall = '0;
    tick();
    chk("t5_req", 32'(s_req), 32'd1);
    chk("t5_addr", s_addr, 32'h200);
    wait_pres("t5_pres", 4, n);
    chk("t5_inst", s_inst, 32'hA5A5_0200);

    // PC wrap, redirect taken while PC stage stalled
    lat = 0;
    do_reset();
    stall = 6'b000001;
    ex_b_flag = 1'b1; ex_b_target = 32'hFFFF_FFFC;
    tick();
    chk("t6_stalled_req", 32'(s_req), 32'd0);
    ex_b_flag = 1'b0; stall = '0;
    tick();
    chk("t6_addr_top", s_addr, 32'hFFFF_FFFC);
    tick();
    chk("t6_pc", s_pc, 32'hFFFF_FFFC);
    chk("t6_inst", s_inst, 32'h5A5A_FFFC);
    tick();
    chk("t6_wrap_req", 32'(s_req), 32'd1);
    chk("t6_wrap_addr", s_addr, 32'h0);

    // Reset mid-transaction, late response during reset
    lat = 3;
    do_reset();
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("t7_req_async", 32'(mem_req), 32'd0);
    force_rdy = 1'b1;
    tick();
    tick();
    force_rdy = 1'b0;
    rst = 1'b1;
    acc_pc.delete();
    acc_inst.delete();
    tick();
    chk("t7_req", 32'(s_req), 32'd1);
    chk("t7_addr", s_addr, RESET_PC);
    chk("t7_stallreq", 32'(s_sr), 32'd1);
    wait_pres("t7_pres", 10, n);
    chk("t7_latency", 32'(n), 32'd4);
    chk("t7_pc", s_pc, RESET_PC);
    chk("t7_inst", s_inst, 32'hA5A5_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
